bg_text_fetch: RTL and testbench

Per-scanline fetch engine for one text-mode background layer (bgmode 0/1).
- Walks screen x = 0..SCREEN_WIDTH-1: screen-entry fetch, then character halfword fetch.
- Issues bg_screen_addr/bg_addr to vram_controller and consumes bg_screen_data/bg_data.
- Emits one palette index per pixel over a valid/ready stream into the downstream line buffer / compositor.

---
 rtl/bg_text_fetch.sv | 235 +++++++++++++++++++++++
 tb/tb_bg_text_fetch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bg_text_fetch.sv
// Per-scanline fetch engine for one text-mode background layer: map entry fetch,
// character halfword fetch, one palette index per pixel. Optional mosaic: BG_MOSAIC_EN.
module bg_text_fetch #(
    parameter int SCREEN_WIDTH = 240
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  line,
    input  logic [8:0]  hofs,
    input  logic [8:0]  vofs,
    input  logic [1:0]  char_base,
    input  logic [4:0]  screen_base,
    input  logic        color_256,
    input  logic [1:0]  screen_size,
`ifdef BG_MOSAIC_EN
    input  logic        mosaic_en,
    input  logic [3:0]  mosaic_h,
    input  logic [3:0]  mosaic_v,
`endif
    output logic [15:0] bg_screen_addr,
    input  logic [15:0] bg_screen_data,
    output logic [16:0] bg_addr,
    input  logic [15:0] bg_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_index,
    output logic [7:0]  pix_x,
    output logic        pix_transparent,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        MAP_REQ,
        MAP_WAIT,
        CHR_REQ,
        CHR_WAIT,
        EMIT
    } state_t;

    localparam logic [8:0] LAST_X = 9'(SCREEN_WIDTH);

    state_t      state;
    logic [8:0]  sx;
    logic [8:0]  vx;
    logic [8:0]  y;
    logic [1:0]  cb_q;
    logic [4:0]  sb_q;
    logic        c256_q;
    logic [1:0]  size_q;
    logic [9:0]  tile_q;
    logic        hflip_q;
    logic        vflip_q;
    logic [3:0]  pal_q;
    logic [15:0] chr_q;

    logic [5:0]  tx;
    logic [5:0]  ty;
    logic [15:0] blk_ofs;
    logic [2:0]  row;
    logic [2:0]  col;
    logic [2:0]  col_next;
    logic [8:0]  vx_inc;
    logic [8:0]  sx_inc;
    logic        hw_change;
    logic [15:0] chr_addr;
    logic [7:0]  line_eff;
    logic        mos_repeat;
    logic        mos_refetch;

    // Returns {transparent, index} for column c of a character halfword.
    function automatic logic [8:0] pixel_of(input logic [15:0] hw, input logic [2:0] c,
                                            input logic wide, input logic [3:0] pal);
        logic [3:0] n;
        logic [7:0] b;
        logic [8:0] res;
        n = hw[{c[1:0], 2'b00} +: 4];
        b = c[0] ? hw[15:8] : hw[7:0];
        if (wide)
            res = {(b == 8'd0), b};
        else
            res = {(n == 4'd0), (n == 4'd0) ? 8'd0 : {pal, n}};
        return res;
    endfunction

`ifdef BG_MOSAIC_EN
    logic       mos_on_q;
    logic [3:0] mos_h_q;
    logic [3:0] mos_cnt;

    assign line_eff    = mosaic_en ? line - (line % ({4'd0, mosaic_v} + 8'd1)) : line;
    assign mos_repeat  = mos_on_q && (mos_cnt != mos_h_q);
    // After a mosaic block the source column has jumped, so the tile must be refetched.
    assign mos_refetch = mos_on_q && (mos_h_q != 4'd0);
`else
    assign line_eff    = line;
    assign mos_repeat  = 1'b0;
    assign mos_refetch = 1'b0;
`endif

    assign tx = vx[8:3];
    assign ty = y[8:3];

    always_comb begin
        blk_ofs = 16'd0;
        case (size_q)
            2'd1:    blk_ofs = {4'd0, tx[5], 11'd0};
            2'd2:    blk_ofs = {4'd0, ty[5], 11'd0};
            2'd3:    blk_ofs = {3'd0, ty[5], tx[5], 11'd0};
            default: blk_ofs = 16'd0;
        endcase
    end

    assign bg_screen_addr = {sb_q, 11'd0} + blk_ofs + {5'd0, ty[4:0], tx[4:0], 1'b0};

    assign row      = vflip_q ? ~y[2:0] : y[2:0];
    assign col      = hflip_q ? ~vx[2:0] : vx[2:0];
    assign vx_inc   = vx + 9'd1;
    assign sx_inc   = sx + 9'd1;
    assign col_next = hflip_q ? ~vx_inc[2:0] : vx_inc[2:0];
    assign hw_change = c256_q ? (col_next[2:1] != col[2:1]) : (col_next[2] != col[2]);

    always_comb begin
        if (c256_q)
            chr_addr = {cb_q, 14'd0} + {tile_q, 6'd0} + {10'd0, row, 3'd0}
                     + {13'd0, col[2:1], 1'b0};
        else
            chr_addr = {cb_q, 14'd0} + {1'b0, tile_q, 5'd0} + {11'd0, row, 2'd0}
                     + {14'd0, col[2], 1'b0};
    end

    assign bg_addr = {1'b0, chr_addr};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sx              <= 9'd0;
            vx              <= 9'd0;
            y               <= 9'd0;
            cb_q            <= 2'd0;
            sb_q            <= 5'd0;
            c256_q          <= 1'b0;
            size_q          <= 2'd0;
            tile_q          <= 10'd0;
            hflip_q         <= 1'b0;
            vflip_q         <= 1'b0;
            pal_q           <= 4'd0;
            chr_q           <= 16'd0;
            pix_valid       <= 1'b0;
            pix_index       <= 8'd0;
            pix_x           <= 8'd0;
            pix_transparent <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
`ifdef BG_MOSAIC_EN
            mos_on_q        <= 1'b0;
            mos_h_q         <= 4'd0;
            mos_cnt         <= 4'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cb_q   <= char_base;
                        sb_q   <= screen_base;
                        c256_q <= color_256;
                        size_q <= screen_size;
                        sx     <= 9'd0;
                        vx     <= hofs;
                        y      <= vofs + {1'b0, line_eff};
                        busy   <= 1'b1;
`ifdef BG_MOSAIC_EN
                        mos_on_q <= mosaic_en;
                        mos_h_q  <= mosaic_h;
                        mos_cnt  <= 4'd0;
`endif
                        state  <= MAP_REQ;
                    end
                end
                MAP_REQ: state <= MAP_WAIT;
                MAP_WAIT: begin
                    tile_q  <= bg_screen_data[9:0];
                    hflip_q <= bg_screen_data[10];
                    vflip_q <= bg_screen_data[11];
                    pal_q   <= bg_screen_data[15:12];
                    state   <= CHR_REQ;
                end
                CHR_REQ: state <= CHR_WAIT;
                CHR_WAIT: begin
                    chr_q <= bg_data;
                    {pix_transparent, pix_index} <= pixel_of(bg_data, col, c256_q, pal_q);
                    pix_x     <= sx[7:0];
                    pix_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (pix_ready) begin
                        sx <= sx_inc;
                        vx <= vx_inc;
                        if (sx_inc == LAST_X) begin
                            pix_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= IDLE;
                        end else if (mos_repeat) begin
                            pix_x <= sx_inc[7:0];
`ifdef BG_MOSAIC_EN
                            mos_cnt <= mos_cnt + 4'd1;
`endif
                        end else begin
`ifdef BG_MOSAIC_EN
                            mos_cnt <= 4'd0;
`endif
                            if (mos_refetch || vx_inc[2:0] == 3'd0) begin
                                pix_valid <= 1'b0;
                                state     <= MAP_REQ;
                            end else if (hw_change) begin
                                pix_valid <= 1'b0;
                                state     <= CHR_REQ;
                            end else begin
                                {pix_transparent, pix_index} <= pixel_of(chr_q, col_next, c256_q, pal_q);
                                pix_x <= sx_inc[7:0];
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_text_fetch.sv
// Bench for bg_text_fetch: fixed vectors for first-fetch addresses and pixels, random
// lines against a per-pixel reference model, back-pressure hold and mid-line reset.
module tb_bg_text_fetch;

    localparam int SCREEN_WIDTH = 240;
    localparam int BUDGET = 3000;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  line;
    logic [8:0]  hofs;
    logic [8:0]  vofs;
    logic [1:0]  char_base;
    logic [4:0]  screen_base;
    logic        color_256;
    logic [1:0]  screen_size;
    logic [15:0] bg_screen_addr;
    logic [15:0] bg_screen_data;
    logic [16:0] bg_addr;
    logic [15:0] bg_data;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  pix_index;
    logic [7:0]  pix_x;
    logic        pix_transparent;
    logic        busy;
    logic        done;

    logic [15:0] vram [0:32767];
    int exp_idx [0:255];
    int exp_tr  [0:255];
    int errors = 0;
    int checks = 0;

    bg_text_fetch #(.SCREEN_WIDTH(SCREEN_WIDTH)) dut (
        .clock(clock), .reset(reset), .start(start), .line(line), .hofs(hofs), .vofs(vofs),
        .char_base(char_base), .screen_base(screen_base), .color_256(color_256),
        .screen_size(screen_size), .bg_screen_addr(bg_screen_addr),
        .bg_screen_data(bg_screen_data), .bg_addr(bg_addr), .bg_data(bg_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_index(pix_index), .pix_x(pix_x),
        .pix_transparent(pix_transparent), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bg_screen_data <= vram[bg_screen_addr[15:1]];
        bg_data        <= vram[bg_addr[15:1]];
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel at screen x, straight from the tile-map and character rules.
    task automatic model_pixel(input int sx, output int idx, output int tr);
        int vx, y, tx, ty, maddr, entry, tile, hf, vf, pal, r, c, caddr, hw, v;
        vx = (int'(hofs) + sx) % 512;
        y  = (int'(line) + int'(vofs)) % 512;
        tx = vx / 8;
        ty = y / 8;
        maddr = int'(screen_base) * 2048 + (ty % 32) * 64 + (tx % 32) * 2;
        if (screen_size == 2'd1 || screen_size == 2'd3) maddr += (tx / 32) * 2048;
        if (screen_size == 2'd2) maddr += (ty / 32) * 2048;
        if (screen_size == 2'd3) maddr += (ty / 32) * 4096;
        maddr = maddr % 65536;
        entry = int'(vram[maddr / 2]);
        tile = entry % 1024;
        hf   = (entry >> 10) & 1;
        vf   = (entry >> 11) & 1;
        pal  = entry >> 12;
        r = (vf != 0) ? 7 - (y % 8) : y % 8;
        c = (hf != 0) ? 7 - (vx % 8) : vx % 8;
        if (color_256 == 1'b0)
            caddr = int'(char_base) * 16384 + tile * 32 + r * 4 + (c / 4) * 2;
        else
            caddr = int'(char_base) * 16384 + tile * 64 + r * 8 + (c / 2) * 2;
        caddr = caddr % 65536;
        hw = int'(vram[caddr / 2]);
        if (color_256 == 1'b0) begin
            v   = (hw >> (4 * (c % 4))) & 15;
            tr  = (v == 0) ? 1 : 0;
            idx = (v == 0) ? 0 : pal * 16 + v;
        end else begin
            v   = (hw >> (8 * (c % 2))) & 255;
            tr  = (v == 0) ? 1 : 0;
            idx = v;
        end
    endtask

    task automatic start_line();
        int a, b;
        for (int i = 0; i < SCREEN_WIDTH; i++) begin
            model_pixel(i, a, b);
            exp_idx[i] = a;
            exp_tr[i]  = b;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic collect(input int ready_pct, input int stall_x, input int abort_x,
                           output bit aborted);
        int k, cyc, early_done, done_cnt;
        bit stalled;
        k = 0; cyc = 0; early_done = 0; stalled = 0; aborted = 0;
        while (k < SCREEN_WIDTH && cyc < BUDGET && !aborted) begin
            if (done) early_done++;
            if (abort_x >= 0 && pix_valid && int'(pix_x) == abort_x) begin
                reset = 1'b1;
                #1;
                chk("reset_abort_outputs", longint'({pix_valid, pix_index, pix_x, pix_transparent,
                                                      busy, done, bg_screen_addr, bg_addr}), 0);
                repeat (3) begin
                    @(negedge clock);
                    chk("reset_no_done", done, 0);
                end
                reset = 1'b0;
                aborted = 1;
            end else begin
                if (stall_x >= 0 && !stalled && pix_valid && int'(pix_x) == stall_x) begin
                    stalled = 1;
                    pix_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clock);
                        cyc++;
                        chk("stall_valid", pix_valid, 1);
                        chk("stall_x", pix_x, k);
                        chk("stall_index", pix_index, exp_idx[k]);
                        chk("stall_transp", pix_transparent, exp_tr[k]);
                    end
                end
                pix_ready = ($urandom_range(0, 99) < ready_pct);
                if (pix_valid && pix_ready) begin
                    chk("pix_x", pix_x, k);
                    chk("pix_index", pix_index, exp_idx[k]);
                    chk("pix_transparent", pix_transparent, exp_tr[k]);
                    k++;
                end
                @(negedge clock);
                cyc++;
            end
        end
        pix_ready = 1'b0;
        if (!aborted) begin
            chk("transfer_count", k, SCREEN_WIDTH);
            chk("early_done", early_done, 0);
            chk("done_after_last", done, 1);
            chk("busy_after_done", busy, 0);
            done_cnt = int'(done);
            repeat (3) begin
                @(negedge clock);
                done_cnt += int'(done);
            end
            chk("done_width", done_cnt, 1);
        end
    endtask

    typedef struct {
        logic [8:0]  hofs;
        logic [8:0]  vofs;
        logic [7:0]  line;
        logic [4:0]  sb;
        logic [1:0]  cb;
        logic        c256;
        logic [1:0]  size;
        logic [15:0] entry;
        logic [15:0] chr;
        logic [15:0] exp_map;
        logic [16:0] exp_chr;
        logic [7:0]  exp_idx;
        logic        exp_tr;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        bit ab;
        reset = 1'b1; start = 1'b0; pix_ready = 1'b0;
        line = 8'd0; hofs = 9'd0; vofs = 9'd0; char_base = 2'd0; screen_base = 5'd0;
        color_256 = 1'b0; screen_size = 2'd0;
        for (int i = 0; i < 32768; i++) vram[i] = 16'($urandom);

        vecs[0] = '{9'd0,   9'd0,   8'd0, 5'd8, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h4321, 16'h4000, 17'h00000, 8'h01, 1'b0};
        vecs[1] = '{9'd0,   9'd0,   8'd2, 5'd8, 2'd0, 1'b0, 2'd0, 16'hF405, 16'hA123, 16'h4000, 17'h000AA, 8'hFA, 1'b0};
        vecs[2] = '{9'd0,   9'd0,   8'd9, 5'd8, 2'd0, 1'b1, 2'd0, 16'h0003, 16'h5500, 16'h4040, 17'h000C8, 8'h00, 1'b1};
        vecs[3] = '{9'd256, 9'd256, 8'd0, 5'd4, 2'd1, 1'b0, 2'd3, 16'h0007, 16'h0000, 16'h3800, 17'h040E0, 8'h00, 1'b1};
        vecs[4] = '{9'd511, 9'd0,   8'd0, 5'd8, 2'd0, 1'b0, 2'd0, 16'h1002, 16'h7000, 16'h403E, 17'h00042, 8'h17, 1'b0};
        vecs[5] = '{9'd0,   9'd0,   8'd3, 5'd8, 2'd2, 1'b1, 2'd0, 16'h0C04, 16'h3CAB, 16'h4000, 17'h08126, 8'h3C, 1'b0};
        vecs[6] = '{9'd264, 9'd0,   8'd0, 5'd2, 2'd0, 1'b0, 2'd1, 16'h0001, 16'h0009, 16'h1802, 17'h00020, 8'h09, 1'b0};
        vecs[7] = '{9'd256, 9'd256, 8'd8, 5'd2, 2'd1, 1'b0, 2'd2, 16'h2001, 16'h000F, 16'h1840, 17'h04020, 8'h2F, 1'b0};

        repeat (3) @(negedge clock);
        chk("reset_outputs", longint'({pix_valid, pix_index, pix_x, pix_transparent, busy, done}), 0);
        chk("reset_addrs", longint'({bg_screen_addr, bg_addr}), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_busy", busy, 0);

        for (int v = 0; v < 8; v++) begin
            hofs = vecs[v].hofs; vofs = vecs[v].vofs; line = vecs[v].line;
            screen_base = vecs[v].sb; char_base = vecs[v].cb;
            color_256 = vecs[v].c256; screen_size = vecs[v].size;
            vram[vecs[v].exp_map[15:1]] = vecs[v].entry;
            vram[vecs[v].exp_chr[15:1]] = vecs[v].chr;
            start_line();
            chk("busy_start", busy, 1);
            chk("first_map_addr", bg_screen_addr, vecs[v].exp_map);
            repeat (2) @(negedge clock);
            chk("first_chr_addr", bg_addr, vecs[v].exp_chr);
            repeat (2) @(negedge clock);
            chk("first_valid", pix_valid, 1);
            chk("first_x", pix_x, 0);
            chk("first_index", pix_index, vecs[v].exp_idx);
            chk("first_transp", pix_transparent, vecs[v].exp_tr);
            collect(100, -1, -1, ab);
        end

        for (int i = 0; i < 32768; i++) vram[i] = 16'($urandom);
        for (int r = 0; r < 6; r++) begin
            hofs = 9'($urandom_range(0, 511)); vofs = 9'($urandom_range(0, 511));
            line = 8'($urandom_range(0, 255)); screen_base = 5'($urandom_range(0, 31));
            char_base = 2'($urandom_range(0, 3)); color_256 = 1'($urandom_range(0, 1));
            screen_size = 2'($urandom_range(0, 3));
            start_line();
            collect((r % 3 == 0) ? 100 : ((r % 3 == 1) ? 70 : 40), -1, -1, ab);
        end

        hofs = 9'd3; vofs = 9'd17; line = 8'd40; screen_base = 5'd6; char_base = 2'd1;
        color_256 = 1'b0; screen_size = 2'd3;
        start_line();
        collect(100, 7, -1, ab);

        start_line();
        collect(100, -1, 100, ab);
        chk("abort_taken", ab, 1);
        start_line();
        collect(80, -1, -1, ab);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
